// File: rtl/tdm_demux14.sv
// Time-division 1-to-4 demultiplexer: aligns to frame_sync on slot 0 and steers
// each accepted beat into one of four held channel registers.

module tdm_demux14_lane #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst)        q <= '0;
      else if (wr_en) q <= d;
   end
endmodule

module tdm_demux14 #(
   parameter int WIDTH = 1,
   parameter int ERRW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic [3:0]       ch_valid,
   output logic             frame_done,
   output logic             locked,
   output logic             sync_err,
   output logic [ERRW-1:0]  err_count
);
   localparam int NUM_CH = 4;

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t                         state;
   logic [1:0]                     slot;
   logic [NUM_CH-1:0]              wr_sel;
   logic [NUM_CH-1:0][WIDTH-1:0]   y_q;

   // Channel write select; an early sync is re-anchored as a slot-0 write.
   always_comb begin
      wr_sel = '0;
      if (din_valid) begin
         if (frame_sync)       wr_sel = 4'b0001;
         else if (state == LOCKED && slot != 2'd0)
            wr_sel[slot] = 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      tdm_demux14_lane #(.WIDTH(WIDTH)) u_lane (
         .clk   (clk),
         .rst   (rst),
         .wr_en (wr_sel[k]),
         .d     (din),
         .q     (y_q[k])
      );
   end

   assign y0 = y_q[0];
   assign y1 = y_q[1];
   assign y2 = y_q[2];
   assign y3 = y_q[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HUNT;
         slot       <= 2'd0;
         ch_valid   <= '0;
         frame_done <= 1'b0;
         locked     <= 1'b0;
         sync_err   <= 1'b0;
         err_count  <= '0;
      end else begin
         ch_valid   <= wr_sel;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         if (din_valid) begin
            case (state)
               HUNT: begin
                  if (frame_sync) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                     slot   <= 2'd1;
                  end
               end
               LOCKED: begin
                  if (frame_sync) begin
                     slot <= 2'd1;
                     if (slot != 2'd0) begin
                        sync_err <= 1'b1;
                        if (err_count != {ERRW{1'b1}}) err_count <= err_count + ERRW'(1);
                     end
                  end else if (slot == 2'd0) begin
                     // Missing sync: drop the beat and re-hunt.
                     state    <= HUNT;
                     locked   <= 1'b0;
                     sync_err <= 1'b1;
                     if (err_count != {ERRW{1'b1}}) err_count <= err_count + ERRW'(1);
                  end else begin
                     slot <= slot + 2'd1;
                     if (slot == 2'd3) frame_done <= 1'b1;
                  end
               end
               default: begin
                  state  <= HUNT;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_tdm_demux14.sv
// Directed bench for tdm_demux14: frame alignment, sync errors, gaps, reset and
// error-counter saturation (second instance with ERRW=2).

module tb_tdm_demux14;
   logic       clk = 1'b0;
   logic       rst;
   logic [0:0] din;
   logic       din_valid;
   logic       frame_sync;

   logic [0:0] y0, y1, y2, y3;
   logic [3:0] ch_valid;
   logic       frame_done, locked, sync_err;
   logic [7:0] err_count;

   logic [0:0] s_y0, s_y1, s_y2, s_y3;
   logic [3:0] s_ch_valid;
   logic       s_frame_done, s_locked, s_sync_err;
   logic [1:0] s_err_count;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   tdm_demux14 #(.WIDTH(1), .ERRW(8)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3), .ch_valid(ch_valid), .frame_done(frame_done),
      .locked(locked), .sync_err(sync_err), .err_count(err_count)
   );

   tdm_demux14 #(.WIDTH(1), .ERRW(2)) dut_sat (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
      .y0(s_y0), .y1(s_y1), .y2(s_y2), .y3(s_y3), .ch_valid(s_ch_valid),
      .frame_done(s_frame_done), .locked(s_locked), .sync_err(s_sync_err),
      .err_count(s_err_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one beat, let one edge sample it, then settle before checking.
   task automatic step(input logic v, input logic fs, input logic d);
      din_valid  = v;
      frame_sync = fs;
      din        = d;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_st(input string name, input logic [3:0] ey, input logic [3:0] ecv,
                            input logic efd, input logic elk, input logic ese,
                            input logic [7:0] eerr);
      check({name, ".y"},   {28'd0, y3, y2, y1, y0}, {28'd0, ey});
      check({name, ".chv"}, {28'd0, ch_valid}, {28'd0, ecv});
      check({name, ".fd"},  {31'd0, frame_done}, {31'd0, efd});
      check({name, ".lk"},  {31'd0, locked}, {31'd0, elk});
      check({name, ".se"},  {31'd0, sync_err}, {31'd0, ese});
      check({name, ".err"}, {24'd0, err_count}, {24'd0, eerr});
   endtask

   initial begin
      rst = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
      step(0, 0, 0);
      step(0, 0, 0);
      expect_st("rst", 4'b0000, 4'b0000, 0, 0, 0, 8'd0);
      check("rst.sat_err", {30'd0, s_err_count}, 32'd0);
      rst = 1'b0;

      // Frame {1,0,1,0} then {0,1,0,1}; y listed as {y3,y2,y1,y0}
      step(1, 1, 1); expect_st("f1b0", 4'b0001, 4'b0001, 0, 1, 0, 8'd0);
      step(1, 0, 0); expect_st("f1b1", 4'b0001, 4'b0010, 0, 1, 0, 8'd0);
      step(1, 0, 1); expect_st("f1b2", 4'b0101, 4'b0100, 0, 1, 0, 8'd0);
      step(1, 0, 0); expect_st("f1b3", 4'b0101, 4'b1000, 1, 1, 0, 8'd0);
      step(0, 0, 0); expect_st("idle", 4'b0101, 4'b0000, 0, 1, 0, 8'd0);
      step(1, 1, 0); expect_st("f2b0", 4'b0100, 4'b0001, 0, 1, 0, 8'd0);
      step(1, 0, 1); expect_st("f2b1", 4'b0110, 4'b0010, 0, 1, 0, 8'd0);
      step(1, 0, 0); expect_st("f2b2", 4'b0010, 4'b0100, 0, 1, 0, 8'd0);
      step(1, 0, 1); expect_st("f2b3", 4'b1010, 4'b1000, 1, 1, 0, 8'd0);

      // Missing sync at slot 0
      step(1, 0, 1); expect_st("miss", 4'b1010, 4'b0000, 0, 0, 1, 8'd1);
      // HUNT drops unsynced beats silently
      step(1, 0, 1); expect_st("hunt0", 4'b1010, 4'b0000, 0, 0, 0, 8'd1);
      step(1, 0, 1); expect_st("hunt1", 4'b1010, 4'b0000, 0, 0, 0, 8'd1);
      step(1, 1, 1); expect_st("relock", 4'b1011, 4'b0001, 0, 1, 0, 8'd1);
      step(1, 0, 0); expect_st("rl_b1", 4'b1001, 4'b0010, 0, 1, 0, 8'd1);

      // Early sync at slot 2 re-anchors to slot 0
      step(1, 1, 0); expect_st("early", 4'b1000, 4'b0001, 0, 1, 1, 8'd2);
      step(1, 0, 1); expect_st("er_b1", 4'b1010, 4'b0010, 0, 1, 0, 8'd2);
      step(1, 0, 1); expect_st("er_b2", 4'b1110, 4'b0100, 0, 1, 0, 8'd2);
      step(1, 0, 0); expect_st("er_b3", 4'b0110, 4'b1000, 1, 1, 0, 8'd2);

      // Gapped frame {1,0,0,1}, frame_sync on invalid cycles ignored
      step(1, 1, 1); expect_st("g_b0", 4'b0111, 4'b0001, 0, 1, 0, 8'd2);
      step(0, 1, 0); expect_st("g_gap0", 4'b0111, 4'b0000, 0, 1, 0, 8'd2);
      step(0, 0, 0);
      step(1, 0, 0); expect_st("g_b1", 4'b0101, 4'b0010, 0, 1, 0, 8'd2);
      step(0, 1, 1);
      step(0, 0, 0);
      step(0, 1, 0); expect_st("g_gap1", 4'b0101, 4'b0000, 0, 1, 0, 8'd2);
      step(1, 0, 0); expect_st("g_b2", 4'b0001, 4'b0100, 0, 1, 0, 8'd2);
      step(1, 0, 1); expect_st("g_b3", 4'b1001, 4'b1000, 1, 1, 0, 8'd2);

      // Reset mid-frame
      step(1, 1, 0); expect_st("r_b0", 4'b1000, 4'b0001, 0, 1, 0, 8'd2);
      step(1, 0, 1); expect_st("r_b1", 4'b1010, 4'b0010, 0, 1, 0, 8'd2);
      rst = 1'b1;
      step(1, 0, 1); expect_st("midrst", 4'b0000, 4'b0000, 0, 0, 0, 8'd0);
      rst = 1'b0;
      step(1, 0, 1); expect_st("post_rst_hunt", 4'b0000, 4'b0000, 0, 0, 0, 8'd0);

      // Five missing-sync errors: ERRW=2 counter stops at 3
      for (int i = 1; i <= 5; i++) begin
         step(1, 1, 1);
         step(1, 0, 0);
         step(1, 0, 0);
         step(1, 0, 0);
         step(1, 0, 0);
         check($sformatf("sat%0d.se", i), {31'd0, sync_err}, 32'd1);
         check($sformatf("sat%0d.lk", i), {31'd0, locked}, 32'd0);
         check($sformatf("sat%0d.chv", i), {28'd0, ch_valid}, 32'd0);
         check($sformatf("sat%0d.err", i), {24'd0, err_count}, i);
         check($sformatf("sat%0d.sat_err", i), {30'd0, s_err_count}, (i > 3) ? 32'd3 : i);
      end
      step(0, 0, 0);
      check("sat_hold", {30'd0, s_err_count}, 32'd3);
      check("sat_se_clr", {31'd0, s_sync_err}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/tdm_demux14.md
Name: tdm_demux14

Overview:
- Time-division 1-to-4 demultiplexer, the receive-side counterpart of the team's 4:1 channel mux.
- Accepts a serialized stream of beats, one beat per channel slot, with a frame-sync marker on the slot-0 beat.
- Aligns to frame-sync and steers each beat to one of four registered channel outputs.
- Flags misalignment and counts sync errors.
- Sits between the serial link and the per-channel consumers.

Parameters:
- WIDTH, 1, data width of each beat and of each channel output.
- ERRW, 8, width of the saturating sync-error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- din  input  WIDTH  serial beat data.
- din_valid  input  1  beat present this cycle.
- frame_sync  input  1  marks the current beat as slot 0. Only meaningful when din_valid=1.
- y0  output  WIDTH  channel 0 held data.
- y1  output  WIDTH  channel 1 held data.
- y2  output  WIDTH  channel 2 held data.
- y3  output  WIDTH  channel 3 held data.
- ch_valid  output  4  one-cycle pulse; bit k=1 when yk was updated this cycle.
- frame_done  output  1  one-cycle pulse when slot 3 of an aligned frame is written.
- locked  output  1  1 while in LOCKED state.
- sync_err  output  1  one-cycle pulse on a detected misalignment.
- err_count  output  ERRW  saturating count of sync_err pulses.

Behaviour:
- Reset:
  - Synchronous, active-high; takes priority over all other activity.
  - Next edge with rst=1: state=HUNT, slot=0, y0..y3=0, ch_valid=0, frame_done=0, locked=0, sync_err=0, err_count=0.
  - Applies mid-frame: partial frame abandoned, no pulses emitted.
- Beat acceptance: a beat is accepted only on a cycle with din_valid=1. With din_valid=0, frame_sync is ignored and no state or data changes; all pulse outputs go to 0 on the next edge.
- Latency: an accepted beat appears on yk, with ch_valid[k]=1, on the edge that samples it, i.e. visible the cycle after presentation. yk holds its value until overwritten.
- State HUNT:
  - Beat with frame_sync=1: write y0, ch_valid=4'b0001, slot<=1, go LOCKED.
  - Beat with frame_sync=0: dropped, no outputs, no error.
- State LOCKED (slot s = expected slot):
  - frame_sync=0 and s!=0: write ys, ch_valid[s]=1, slot<=s+1 mod 4. If s=3, frame_done=1 in the same cycle and slot<=0.
  - frame_sync=1 and s=0: normal slot-0 write, slot<=1.
  - frame_sync=1 and s!=0 (early sync): sync_err=1, err_count+1. Beat treated as slot 0: write y0, ch_valid=4'b0001, slot<=1. Stay LOCKED. No frame_done.
  - frame_sync=0 and s=0 (missing sync): sync_err=1, err_count+1, beat dropped, no channel write, go HUNT, locked<=0.
- err_count saturates at 2^ERRW-1 and never wraps.
- Pulse outputs (ch_valid, frame_done, sync_err) are high for exactly one cycle per event.
- At most one ch_valid bit is high in any cycle.
- Gaps (din_valid=0) between beats of a frame are legal and do not break alignment.

Test Plan:
- Reset, then frame {1,0,1,0} (WIDTH=1, sync on first beat) with din_valid=1 each cycle -> ch_valid 0001,0010,0100,1000 on consecutive cycles; y0=1,y1=0,y2=1,y3=0; frame_done on 4th; locked=1 from 1st.
- Beats with frame_sync=0 before any sync -> no writes, locked=0, err_count=0; then sync beat -> y0 written, locked=1.
- LOCKED at slot 2, beat with frame_sync=1, din=1 -> sync_err pulse, err_count=1, y0=1, next beat lands on y1.
- LOCKED at slot 0, beat with frame_sync=0 -> sync_err pulse, locked=0, no ch_valid, y0 unchanged.
- Frame with din_valid gaps of 0-3 cycles between beats, plus frame_sync=1 on a din_valid=0 cycle -> identical results to the gapless frame, no error.
- rst asserted after slot 1 of a frame -> all outputs 0 next cycle, HUNT. With ERRW=2, drive 5 missing-sync errors -> err_count stops at 3.
